// File: rtl/rom_ram_copier_if.sv
// Bus bundle between the copier and the lab ROM/RAM plus its start/done front end.
`timescale 1ns/1ps
interface rom_ram_copier_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W:0]   err_cnt;

    modport master (
        input  start, rom_data, ram_dout,
        output rom_addr, ram_addr, ram_din, ram_we, busy, done, pass, err_cnt
    );

    modport slave (
        output start, rom_data, ram_dout,
        input  rom_addr, ram_addr, ram_din, ram_we, busy, done, pass, err_cnt
    );
endinterface

// File: rtl/rom_ram_copier.sv
// Copies every ROM word (XOR MASK) into RAM, then reads RAM back against ROM and counts mismatches.
// state  | meaning
// IDLE   | waiting for start, buses parked at 0
// COPY   | write rom_data^MASK to RAM at idx
// VERIFY | compare RAM against rom_data^MASK at idx
// DONE   | one-cycle done pulse, latch pass
`timescale 1ns/1ps
module rom_ram_copier #(
    parameter int                ADDR_W = 3,
    parameter int                DATA_W = 4,
    parameter logic [DATA_W-1:0] MASK   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    rom_ram_copier_if.master bus
);
    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ERR_MAX  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_VERIFY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] din_s;
    logic [DATA_W-1:0] exp_s;
    logic              we_s;

    assign exp_s = bus.rom_data ^ MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        pass_d    = pass_q;
        addr_s    = '0;
        din_s     = '0;
        we_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_COPY;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    pass_d    = 1'b0;
                end
            end
            S_COPY: begin
                addr_s = idx_q;
                din_s  = exp_s;
                we_s   = 1'b1;
                idx_d  = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_VERIFY;
            end
            S_VERIFY: begin
                addr_s = idx_q;
                // saturation keeps the counter inside ADDR_W+1 bits
                if ((bus.ram_dout != exp_s) && (err_cnt_q != ERR_MAX)) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                pass_d  = (err_cnt_q == '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.rom_addr = addr_s;
    assign bus.ram_addr = addr_s;
    assign bus.ram_din  = din_s;
    assign bus.ram_we   = we_s;
    assign bus.busy     = (state_q == S_COPY) || (state_q == S_VERIFY);
    assign bus.done     = (state_q == S_DONE);
    assign bus.pass     = pass_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_rom_ram_copier.sv
// Scoreboard bench for rom_ram_copier: two instances (MASK 0 and F) share start and the 2i+1 ROM.
`timescale 1ns/1ps
module tb_rom_ram_copier;
    localparam int AW = 3;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic corrupt = 1'b0;

    always #5 clk = ~clk;

    rom_ram_copier_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    rom_ram_copier_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    rom_ram_copier #(.ADDR_W(AW), .DATA_W(DW), .MASK(4'h0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master));
    rom_ram_copier #(.ADDR_W(AW), .DATA_W(DW), .MASK(4'hF)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master));

    logic [DW-1:0] ram0 [8];
    logic [DW-1:0] ram1 [8];

    function automatic logic [3:0] rom_f(input logic [2:0] a);
        return {a, 1'b1};
    endfunction

    function automatic logic [3:0] bad_f(input logic [2:0] a, input logic c);
        return (c && (a == 3'd3 || a == 3'd6)) ? 4'h1 : 4'h0;
    endfunction

    assign if0.start    = start;
    assign if1.start    = start;
    assign if0.rom_data = rom_f(if0.rom_addr);
    assign if1.rom_data = rom_f(if1.rom_addr);
    assign if0.ram_dout = ram0[if0.ram_addr] ^ bad_f(if0.ram_addr, corrupt);
    assign if1.ram_dout = ram1[if1.ram_addr] ^ bad_f(if1.ram_addr, corrupt);

    always @(posedge clk) begin
        if (if0.ram_we) ram0[if0.ram_addr] <= if0.ram_din;
        if (if1.ram_we) ram1[if1.ram_addr] <= if1.ram_din;
    end

    typedef struct {int cyc; logic [2:0] addr; logic [3:0] data;} wr_t;
    typedef struct {int cyc; int err;} dn_t;

    wr_t wq0 [$];
    wr_t wq1 [$];
    dn_t dq [$];
    wr_t w;
    dn_t d;
    dn_t dn_new;
    wr_t wr_new;

    int   cyc = 0;
    int   m_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_done = 0;
    logic pend = 1'b0;
    logic pend_exp = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a pass is 17 cycles from acceptance (16 busy + 1 done).
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (clk) cyc++;
        if (!rst_n) begin
            m_cnt = 0;
            wq0.delete();
            wq1.delete();
            dq.delete();
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (start) begin
            m_cnt = 17;
            for (int i = 0; i < 8; i++) begin
                wr_new.cyc  = cyc + i;
                wr_new.addr = 3'(i);
                wr_new.data = rom_f(3'(i));
                wq0.push_back(wr_new);
                wr_new.data = rom_f(3'(i)) ^ 4'hF;
                wq1.push_back(wr_new);
            end
            dn_new.cyc = cyc + 16;
            dn_new.err = corrupt ? 2 : 0;
            dq.push_back(dn_new);
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            check_eq("busy0", if0.busy, m_cnt >= 2);
            check_eq("busy1", if1.busy, m_cnt >= 2);
            check_eq("done0", if0.done, m_cnt == 1);
            check_eq("done1", if1.done, m_cnt == 1);
            if (pend) begin
                check_eq("pass0", if0.pass, pend_exp);
                check_eq("pass1", if1.pass, pend_exp);
                pend = 1'b0;
            end
            if (if0.ram_we) begin
                check_eq("wr0_expected", wq0.size() > 0, 1);
                if (wq0.size() > 0) begin
                    w = wq0.pop_front();
                    check_eq("wr0_cyc", cyc, w.cyc);
                    check_eq("wr0_addr", if0.ram_addr, w.addr);
                    check_eq("wr0_data", if0.ram_din, w.data);
                end
            end
            if (if1.ram_we) begin
                check_eq("wr1_expected", wq1.size() > 0, 1);
                if (wq1.size() > 0) begin
                    w = wq1.pop_front();
                    check_eq("wr1_cyc", cyc, w.cyc);
                    check_eq("wr1_addr", if1.ram_addr, w.addr);
                    check_eq("wr1_data", if1.ram_din, w.data);
                end
            end
            if (if0.done) begin
                n_done++;
                check_eq("done_expected", dq.size() > 0, 1);
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    check_eq("done_cyc", cyc, d.cyc);
                    check_eq("err0", if0.err_cnt, d.err);
                    check_eq("err1", if1.err_cnt, d.err);
                    pend     = 1'b1;
                    pend_exp = (d.err == 0);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && m_cnt != 0; i++) step(1);
        check_eq("idle_timeout", m_cnt, 0);
        step(1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy0"}, if0.busy, 0);
        check_eq({tag, "_done0"}, if0.done, 0);
        check_eq({tag, "_pass0"}, if0.pass, 0);
        check_eq({tag, "_err0"}, if0.err_cnt, 0);
        check_eq({tag, "_we0"}, if0.ram_we, 0);
        check_eq({tag, "_addr0"}, if0.rom_addr, 0);
        check_eq({tag, "_busy1"}, if1.busy, 0);
        check_eq({tag, "_err1"}, if1.err_cnt, 0);
        check_eq({tag, "_we1"}, if1.ram_we, 0);
        check_eq({tag, "_din1"}, if1.ram_din, 0);
    endtask

    initial begin
        step(3);
        check_zero("rst");
        rst_n = 1'b1;
        step(2);

        // clean pass, both masks
        pulse_start();
        wait_idle();
        for (int i = 0; i < 8; i++) begin
            check_eq("ram0", ram0[i], rom_f(3'(i)));
            check_eq("ram1", ram1[i], rom_f(3'(i)) ^ 4'hF);
        end
        check_eq("t1_pass", if0.pass, 1);

        // readback corruption at addresses 3 and 6
        corrupt = 1'b1;
        pulse_start();
        wait_idle();
        corrupt = 1'b0;
        check_eq("t2_err", if0.err_cnt, 2);
        check_eq("t2_pass", if0.pass, 0);

        // second start pulse during COPY is ignored
        pulse_start();
        step(3);
        pulse_start();
        wait_idle();

        // async reset mid-VERIFY, then a clean pass
        corrupt = 1'b1;
        pulse_start();
        step(12);
        check_eq("t4_err_pre", if0.err_cnt, 1);
        check_eq("t4_busy_pre", if0.busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        step(2);
        rst_n = 1'b1;
        corrupt = 1'b0;
        step(1);
        pulse_start();
        wait_idle();
        check_eq("t4_pass0", if0.pass, 1);
        check_eq("t4_pass1", if1.pass, 1);

        // start held high: back-to-back passes
        n_done = 0;
        start = 1'b1;
        step(36);
        start = 1'b0;
        wait_idle();
        check_eq("t5_done_count", n_done, 2);

        check_eq("wq0_drain", wq0.size(), 0);
        check_eq("wq1_drain", wq1.size(), 0);
        check_eq("dq_drain", dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 100000", $time);
        $fatal(1, "watchdog");
    end
endmodule
